max7219_sequencer: RTL and testbench
====================================

// Module: max7219_sequencer
// PURPOSE
//   Command sequencer directly upstream of the max7219 serial driver. After reset it
//   issues the MAX7219 init register sequence, then on each refresh request writes the
//   clock's BCD digits (and brightness when it changes) as single register writes over
//   the driver's stb/busy handshake. Sits between the clock/BCD logic and max7219.
// PARAMETERS
//   NUM_DIGITS   6      digits driven (1..8); digit k -> MAX7219 addr k+1; scan limit = NUM_DIGITS-1
//   DECODE_MASK  8'hFF  value written to decode-mode register (addr 0x9)
//   TIMEOUT      64     max cycles waiting on any driver handshake edge before fault
// PORTS
//   i_clk          in   1               system clock
//   i_reset_n      in   1               synchronous active-low reset
//   i_ena          in   1               enable; when low, FSM holds state, o_stb forced low
//   i_refresh      in   1               one-cycle request: rewrite all digits
//   i_digits       in   4*NUM_DIGITS    BCD digits, digit0 in [3:0]
//   i_dp           in   NUM_DIGITS      decimal point per digit
//   i_brightness   in   4               intensity code for register 0xA
//   o_stb          out  1               write strobe to driver
//   o_addr         out  4               driver register address
//   o_data         out  8               driver register data
//   i_busy         in   1               driver busy
//   o_init_done    out  1               high once init sequence completed
//   o_busy         out  1               high whenever FSM not in IDLE
//   o_fault        out  1               one-cycle pulse on handshake timeout
// BEHAVIOUR
//   Reset (i_reset_n low at posedge): state=INIT, step=0, o_stb=0, o_addr=0, o_data=0,
//   o_init_done=0, o_fault=0, pending refresh=0, last brightness=0, timeout cnt=0.
//   Init sequence (fixed order, one write each): {C,00} shutdown, {9,DECODE_MASK},
//   {A,i_brightness}, {B,NUM_DIGITS-1}, {F,00} test off, {C,01} normal. Then
//   o_init_done=1 (stays 1 until reset/fault), record brightness, set pending refresh.
//   Write handshake (every write): ISSUE: o_addr/o_data registered, o_stb=1, held stable
//   until i_busy sampled 1; next cycle o_stb=0, go WAIT. WAIT: until i_busy sampled 0,
//   then advance step. Min 3 cycles per write beyond driver time. i_busy already high on
//   entry to ISSUE: wait (stb low) until it drops first.
//   IDLE priorities, evaluated each cycle: 1) i_brightness != recorded -> write {A,new},
//   record it; 2) pending refresh -> snapshot i_digits/i_dp into regs, clear pending,
//   write digits 0..NUM_DIGITS-1 in order, data = {dp, 3'b000, bcd}, addr = k+1.
//   Inputs change mid-sweep: ignored (snapshot). i_refresh during sweep or brightness
//   write: sets pending; exactly one extra sweep follows, regardless of pulse count.
//   i_refresh same cycle as leaving IDLE: captured, not lost.
//   States: INIT_ISSUE, INIT_WAIT, IDLE, UPD_ISSUE, UPD_WAIT, FAULT.
//   Timeout: counter clears on each ISSUE/WAIT entry; reaching TIMEOUT in ISSUE (no busy
//   rise) or WAIT (busy stuck) -> o_stb=0, o_fault pulse, o_init_done=0, restart init
//   at step 0 next cycle (FAULT lasts one cycle).
//   i_ena low: all registers hold, timeout counter frozen, o_stb=0 combinationally gated;
//   handshake resumes where it was when i_ena returns high.
//   Reset mid-write: abort immediately, outputs to reset values, init restarts.
// TESTING
//   Reset then run with driver+mock display -> six writes in order C/00,9/FF,A/br,B/05,
//   F/00,C/01; o_init_done rises after last; initial sweep shows all six digits.
//   i_digits=24'h123456, i_refresh pulse -> addrs 1..6 data 06,05,04,03,02,01; mock
//   7seg->BCD decodes digit0=6 ... digit5=1; o_busy low afterwards.
//   Change i_digits mid-sweep and pulse i_refresh twice -> first sweep uses snapshot,
//   exactly one more sweep with new value, then IDLE.
//   i_brightness 7->3 while idle -> single write {A,03}, no digit writes.
//   Tie i_busy=0 (no driver) -> o_stb held TIMEOUT cycles, o_fault pulses once,
//   o_init_done=0, init restarts at {C,00}.
//   Drop i_ena for 20 cycles mid-WAIT, and assert reset mid-sweep -> no extra/lost writes
//   on resume; after reset o_stb=0 and sequence restarts from init step 0.

Source files
------------

// File: rtl/max7219_sequencer.sv
// max7219_sequencer: issues the MAX7219 init sequence, then digit sweeps and brightness updates as single driver writes.
// Ports: i_clk/i_reset_n (sync, active low); i_ena freezes the FSM and gates o_stb;
// i_refresh requests a digit sweep; i_digits/i_dp/i_brightness are the display content;
// o_stb/o_addr/o_data/i_busy form the driver handshake; o_init_done, o_busy (not IDLE)
// and o_fault (handshake timeout pulse) report status.
module max7219_sequencer #(
  parameter int         NUM_DIGITS  = 6,
  parameter logic [7:0] DECODE_MASK = 8'hFF,
  parameter int         TIMEOUT     = 64
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_ena,
  input  logic                    i_refresh,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [3:0]              i_brightness,
  output logic                    o_stb,
  output logic [3:0]              o_addr,
  output logic [7:0]              o_data,
  input  logic                    i_busy,
  output logic                    o_init_done,
  output logic                    o_busy,
  output logic                    o_fault
);
  typedef enum logic [2:0] {INIT_ISSUE, INIT_WAIT, IDLE, UPD_ISSUE, UPD_WAIT, FAULT} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t                  r_state, w_state;
  logic [2:0]              r_step, w_step;
  logic                    r_stb, w_stb;
  logic [3:0]              r_addr, w_addr;
  logic [7:0]              r_data, w_data;
  logic                    r_init_done, w_init_done;
  logic                    r_pend, w_pend;
  logic                    r_is_br, w_is_br;
  logic [3:0]              r_bright, w_bright;
  logic [CW-1:0]           r_cnt, w_cnt;
  logic [4*NUM_DIGITS-1:0] r_dig, w_dig;
  logic [NUM_DIGITS-1:0]   r_dp, w_dp;
  logic [31:0]             w_dig32;
  logic [7:0]              w_dp8;
  logic [3:0]              w_wr_addr;
  logic [7:0]              w_wr_data;
  logic                    w_timeout;
  assign w_dig32   = 32'(r_dig);
  assign w_dp8     = 8'(r_dp);
  assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
  // Register write for the current step: init table, brightness update, or snapshot digit.
  always_comb begin
    {w_wr_addr, w_wr_data} = {4'hC, 8'h00};
    if (r_state == INIT_ISSUE)
      case (r_step)
        3'd1:    {w_wr_addr, w_wr_data} = {4'h9, DECODE_MASK};
        3'd2:    {w_wr_addr, w_wr_data} = {4'hA, 4'h0, i_brightness};
        3'd3:    {w_wr_addr, w_wr_data} = {4'hB, 8'(NUM_DIGITS - 1)};
        3'd4:    {w_wr_addr, w_wr_data} = {4'hF, 8'h00};
        3'd5:    {w_wr_addr, w_wr_data} = {4'hC, 8'h01};
        default: {w_wr_addr, w_wr_data} = {4'hC, 8'h00};
      endcase
    else if (r_is_br)
      {w_wr_addr, w_wr_data} = {4'hA, 4'h0, r_bright};
    else
      {w_wr_addr, w_wr_data} = {{1'b0, r_step} + 4'd1, w_dp8[r_step], 3'b000, w_dig32[{r_step, 2'b00} +: 4]};
  end
  always_comb begin
    w_state     = r_state;
    w_step      = r_step;
    w_stb       = r_stb;
    w_addr      = r_addr;
    w_data      = r_data;
    w_init_done = r_init_done;
    w_pend      = r_pend;
    w_is_br     = r_is_br;
    w_bright    = r_bright;
    w_cnt       = r_cnt;
    w_dig       = r_dig;
    w_dp        = r_dp;
    if (i_ena) begin
      // A refresh arriving in any state, even the cycle a sweep starts, leaves one sweep pending.
      w_pend = r_pend | i_refresh;
      case (r_state)
        INIT_ISSUE, UPD_ISSUE: begin
          if (r_stb && i_busy) begin
            w_stb   = 1'b0;
            w_cnt   = '0;
            w_state = r_state == INIT_ISSUE ? INIT_WAIT : UPD_WAIT;
          end else if (w_timeout) begin
            w_stb       = 1'b0;
            w_init_done = 1'b0;
            w_state     = FAULT;
          end else begin
            w_cnt = r_cnt + 1'b1;
            // Strobe only once the driver is idle, so a leftover busy is waited out with stb low.
            if (!r_stb && !i_busy) begin
              w_stb  = 1'b1;
              w_addr = w_wr_addr;
              w_data = w_wr_data;
              // Record the value actually written so a change during init triggers a later update.
              if (r_state == INIT_ISSUE && r_step == 3'd2) w_bright = i_brightness;
            end
          end
        end
        INIT_WAIT, UPD_WAIT: begin
          if (!i_busy) begin
            w_cnt   = '0;
            w_step  = r_step + 3'd1;
            w_state = r_state == INIT_WAIT ? INIT_ISSUE : UPD_ISSUE;
            if (r_state == INIT_WAIT && r_step == 3'd5) begin
              w_step      = '0;
              w_state     = IDLE;
              w_init_done = 1'b1;
              w_pend      = 1'b1;
            end
            if (r_state == UPD_WAIT && (r_is_br || r_step == 3'(NUM_DIGITS - 1))) begin
              w_step  = '0;
              w_state = IDLE;
            end
          end else if (w_timeout) begin
            w_init_done = 1'b0;
            w_state     = FAULT;
          end else
            w_cnt = r_cnt + 1'b1;
        end
        IDLE: begin
          if (i_brightness != r_bright) begin
            w_bright = i_brightness;
            w_is_br  = 1'b1;
            w_step   = '0;
            w_cnt    = '0;
            w_state  = UPD_ISSUE;
          end else if (r_pend) begin
            w_dig   = i_digits;
            w_dp    = i_dp;
            w_pend  = i_refresh;
            w_is_br = 1'b0;
            w_step  = '0;
            w_cnt   = '0;
            w_state = UPD_ISSUE;
          end
        end
        FAULT: begin
          w_step  = '0;
          w_cnt   = '0;
          w_state = INIT_ISSUE;
        end
        default: w_state = INIT_ISSUE;
      endcase
    end
  end
  always_ff @(posedge i_clk)
    if (!i_reset_n) r_state <= INIT_ISSUE;
    else r_state <= w_state;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_step      <= '0;
      r_stb       <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_init_done <= 1'b0;
      r_pend      <= 1'b0;
      r_is_br     <= 1'b0;
      r_bright    <= '0;
      r_cnt       <= '0;
      r_dig       <= '0;
      r_dp        <= '0;
    end else begin
      r_step      <= w_step;
      r_stb       <= w_stb;
      r_addr      <= w_addr;
      r_data      <= w_data;
      r_init_done <= w_init_done;
      r_pend      <= w_pend;
      r_is_br     <= w_is_br;
      r_bright    <= w_bright;
      r_cnt       <= w_cnt;
      r_dig       <= w_dig;
      r_dp        <= w_dp;
    end
  end
  assign o_stb       = r_stb & i_ena;
  assign o_addr      = r_addr;
  assign o_data      = r_data;
  assign o_init_done = r_init_done;
  assign o_busy      = r_state != IDLE;
  assign o_fault     = (r_state == FAULT) & i_ena;
endmodule

// File: tb/tb_max7219_sequencer.sv
// tb_max7219_sequencer: directed and randomized checks of the sequencer against a write-list model and a mock driver.
module tb_max7219_sequencer;
  localparam int ND = 6;
  localparam int TO = 64;
  logic clk = 0, rst_n = 0, ena = 1, refresh = 0, busy = 0, drv_en = 1;
  logic [23:0] digits = 0;
  logic [5:0]  dp = 0;
  logic [3:0]  bright = 0;
  logic        stb, init_done, obusy, fault;
  logic [3:0]  addr;
  logic [7:0]  data;
  int          vectors = 0, miscompares = 0, hold = 0;
  logic [11:0] got_q[$], exp_q[$];
  logic [3:0]  br_model = 0;
  max7219_sequencer #(.NUM_DIGITS(ND), .DECODE_MASK(8'hFF), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_ena(ena), .i_refresh(refresh), .i_digits(digits),
    .i_dp(dp), .i_brightness(bright), .o_stb(stb), .o_addr(addr), .o_data(data),
    .i_busy(busy), .o_init_done(init_done), .o_busy(obusy), .o_fault(fault)
  );
  always #5 clk = ~clk;
  // Mock driver: accepts a strobe when idle, logs the write, stays busy a random time.
  always @(negedge clk) begin
    if (!drv_en) busy = 0;
    else if (busy) begin
      hold--;
      if (hold == 0) busy = 0;
    end else if (stb) begin
      got_q.push_back({addr, data});
      busy = 1;
      hold = $urandom_range(2, 10);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic m_init(input logic [3:0] b);
    exp_q.push_back({4'hC, 8'h00});
    exp_q.push_back({4'h9, 8'hFF});
    exp_q.push_back({4'hA, 4'h0, b});
    exp_q.push_back({4'hB, 8'(ND - 1)});
    exp_q.push_back({4'hF, 8'h00});
    exp_q.push_back({4'hC, 8'h01});
    br_model = b;
  endtask
  task automatic m_sweep(input logic [23:0] d, input logic [5:0] p);
    for (int k = 0; k < ND; k++) begin
      int a, v;
      a = k + 1;
      v = int'((d >> (4 * k)) & 24'hF) + (p[k] ? 128 : 0);
      exp_q.push_back(12'(a * 256 + v));
    end
  endtask
  task automatic m_bright(input logic [3:0] b);
    if (b != br_model) begin
      exp_q.push_back({4'hA, 4'h0, b});
      br_model = b;
    end
  endtask
  task automatic check_writes(input string tag);
    chk({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), i < got_q.size() ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask
  task automatic wait_idle(input string tag);
    int n = 0, run = 0;
    while (run < 4 && n < 5000) begin
      @(negedge clk);
      n++;
      run = (!obusy && !busy) ? run + 1 : 0;
    end
    chk({tag, " idle reached"}, 32'(run >= 4), 1);
  endtask
  task automatic wait_writes(input int n, input string tag);
    int c = 0;
    while (got_q.size() < n && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, " writes seen"}, 32'(got_q.size() >= n), 1);
  endtask
  task automatic pulse_refresh();
    @(negedge clk) refresh = 1;
    @(negedge clk) refresh = 0;
  endtask
  function automatic logic [23:0] rand_bcd();
    logic [23:0] d;
    for (int k = 0; k < ND; k++) d[4*k +: 4] = 4'($urandom_range(0, 9));
    return d;
  endfunction
  initial begin
    logic [3:0] nb;
    int hi_cnt, n;
    logic seen;
    bright = 4'($urandom_range(0, 15));
    digits = rand_bcd();
    dp = 6'($urandom);
    repeat (3) @(negedge clk);
    chk("reset stb", stb, 0);
    chk("reset addr", addr, 0);
    chk("reset data", data, 0);
    chk("reset init_done", init_done, 0);
    chk("reset fault", fault, 0);
    chk("reset busy", obusy, 1);
    rst_n = 1;
    m_init(bright);
    m_sweep(digits, dp);
    wait_idle("init");
    check_writes("init");
    chk("init_done", init_done, 1);
    digits = 24'h123456;
    dp = 0;
    pulse_refresh();
    exp_q = '{12'h106, 12'h205, 12'h304, 12'h403, 12'h502, 12'h601};
    wait_idle("123456");
    check_writes("123456");
    chk("123456 busy low", obusy, 0);
    for (int it = 0; it < 5; it++) begin
      nb = 4'($urandom_range(0, 15));
      @(negedge clk);
      digits = rand_bcd();
      dp = 6'($urandom);
      bright = nb;
      refresh = 1;
      @(negedge clk) refresh = 0;
      m_bright(nb);
      m_sweep(digits, dp);
      wait_idle("rand");
      check_writes($sformatf("rand%0d", it));
    end
    digits = rand_bcd();
    pulse_refresh();
    m_sweep(digits, dp);
    wait_writes(2, "midsweep");
    digits = rand_bcd();
    pulse_refresh();
    repeat (4) @(negedge clk);
    pulse_refresh();
    m_sweep(digits, dp);
    wait_idle("midsweep");
    check_writes("midsweep");
    @(negedge clk) bright = 7;
    m_bright(7);
    wait_idle("br7");
    check_writes("br7");
    @(negedge clk) bright = 3;
    m_bright(3);
    wait_idle("br3");
    check_writes("br7to3");
    digits = rand_bcd();
    pulse_refresh();
    m_sweep(digits, dp);
    wait_writes(2, "ena");
    ena = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("ena low stb %0d", i), stb, 0);
    end
    ena = 1;
    wait_idle("ena");
    check_writes("ena");
    @(negedge clk) drv_en = 0;
    pulse_refresh();
    hi_cnt = 0;
    n = 0;
    seen = 0;
    while (!seen && n < 500) begin
      @(negedge clk);
      n++;
      if (fault) seen = 1;
      else if (stb) hi_cnt++;
    end
    drv_en = 1;
    chk("timeout fault seen", seen, 1);
    chk("fault stb low", stb, 0);
    chk("fault init_done", init_done, 0);
    chk("stb held ~TIMEOUT", 32'(hi_cnt >= TO - 2 && hi_cnt <= TO), 1);
    @(negedge clk);
    chk("fault one cycle", fault, 0);
    m_init(bright);
    m_sweep(digits, dp);
    wait_idle("refault");
    check_writes("after fault");
    digits = rand_bcd();
    pulse_refresh();
    m_sweep(digits, dp);
    wait_writes(3, "rstmid");
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("midreset stb", stb, 0);
    chk("midreset init_done", init_done, 0);
    chk("midreset addr", addr, 0);
    chk("midreset data", data, 0);
    repeat (3) void'(exp_q.pop_back());
    check_writes("pre-reset");
    rst_n = 1;
    m_init(bright);
    m_sweep(digits, dp);
    wait_idle("post-reset");
    check_writes("post-reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
